pps_generator: RTL and testbench

- Transmit-side counterpart of the timestamp counter's PPS receive path.
- Watches the free-running 64-bit stamp counter: upper 32 bits are seconds, lower 32 bits are the fraction in 2^-32 s units.
- Drives a PPS output pulse once per second, at a programmable fractional phase.
- Sits beside the stamp counter in the timestamp core. Its pps_tx can loop back to another board's pps_rx, or to test equipment.

---
 rtl/pps_generator.sv | 155 +++++++++++++++
 tb/tb_pps_generator.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pps_generator.sv
// pps_generator: emits one PPS pulse per second of the stamp counter's time,
// at a programmable fractional phase within the second.
//
// FSM: IDLE -> ARM -> WAIT -> PULSE -> GAP -> WAIT ...
// Control overrides, highest priority first:
//   enable = 0        -> IDLE (pulse dropped, counters hold)
//   time_jump = 1     -> ARM  (any state but IDLE; pulse truncated)
// All inputs are levels or strobes sampled on axi_aclk; there is no
// valid/ready handshake on this block.
module pps_generator #(
   parameter int TIMESTAMP_WIDTH    = 64,
   parameter int C_S_AXI_DATA_WIDTH = 32
) (
   input  logic                          axi_aclk,
   input  logic                          axi_reset,
   input  logic [TIMESTAMP_WIDTH-1:0]    stamp_counter,
   input  logic                          time_jump,
   input  logic                          enable,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] pps_offset,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] pulse_width,
   output logic                          pps_tx,
   output logic [C_S_AXI_DATA_WIDTH-1:0] pps_count,
   output logic [C_S_AXI_DATA_WIDTH-1:0] pps_seconds,
   output logic [C_S_AXI_DATA_WIDTH-1:0] missed_count
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int TW = TIMESTAMP_WIDTH;
   localparam logic [DW-1:0] ZERO    = '0;
   localparam logic [DW-1:0] ONE     = DW'(1);
   localparam logic [TW-1:0] TS_ZERO = '0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_PULSE = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] t_q, t_d;           // target seconds
   logic [DW-1:0] width_q, width_d;   // remaining high cycles
   logic          pps_tx_q, pps_tx_d;
   logic [DW-1:0] count_q, count_d;
   logic [DW-1:0] seconds_q, seconds_d;
   logic [DW-1:0] missed_q, missed_d;

   logic [DW-1:0] s;
   logic [TW-1:0] target;
   logic [DW-1:0] sec_ahead;
   logic          fire;
   logic          late;
   logic          backwards;
   logic [DW-1:0] width_init;

   // Compare terms. The fire test is taken on the modular 64-bit difference
   // so that a target of second 0 armed at second 0xFFFFFFFF waits for the
   // wrap instead of firing at once; away from the wrap this is identical
   // to a plain unsigned >=.
   always_comb begin
      s          = stamp_counter[TW-1 -: DW];
      target     = {t_q, pps_offset};
      sec_ahead  = s - t_q;
      fire       = ($signed(stamp_counter - target) >= $signed(TS_ZERO));
      late       = ($signed(sec_ahead) > $signed(ZERO));
      backwards  = ($signed(t_q - s) > $signed(ONE));
      width_init = (pulse_width == ZERO) ? ONE : pulse_width;
   end

   // Next-state and register updates
   always_comb begin
      state_d   = state_q;
      t_d       = t_q;
      width_d   = width_q;
      pps_tx_d  = 1'b0;
      count_d   = count_q;
      seconds_d = seconds_q;
      missed_d  = missed_q;

      if (!enable) begin
         state_d = ST_IDLE;
      end else if (time_jump && (state_q != ST_IDLE)) begin
         state_d = ST_ARM;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ARM;
            end
            ST_ARM: begin
               t_d     = s + ONE;
               state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (fire) begin
                  state_d   = ST_PULSE;
                  pps_tx_d  = 1'b1;
                  width_d   = width_init;
                  seconds_d = t_q;
                  count_d   = count_q + ONE;
                  if (late) begin
                     missed_d = missed_q + sec_ahead;
                     t_d      = s + ONE;
                  end else begin
                     t_d = t_q + ONE;
                  end
               end else if (backwards) begin
                  state_d = ST_ARM;
               end
            end
            ST_PULSE: begin
               if (width_q <= ONE) begin
                  state_d = ST_GAP;
               end else begin
                  pps_tx_d = 1'b1;
                  width_d  = width_q - ONE;
               end
            end
            ST_GAP: begin
               state_d = ST_WAIT;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and counter registers with synchronous reset
   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         state_q   <= ST_IDLE;
         t_q       <= '0;
         width_q   <= '0;
         pps_tx_q  <= 1'b0;
         count_q   <= '0;
         seconds_q <= '0;
         missed_q  <= '0;
      end else begin
         state_q   <= state_d;
         t_q       <= t_d;
         width_q   <= width_d;
         pps_tx_q  <= pps_tx_d;
         count_q   <= count_d;
         seconds_q <= seconds_d;
         missed_q  <= missed_d;
      end
   end

   assign pps_tx       = pps_tx_q;
   assign pps_count    = count_q;
   assign pps_seconds  = seconds_q;
   assign missed_count = missed_q;

endmodule

// File: tb/tb_pps_generator.sv
// tb_pps_generator: directed scenarios plus randomized rounds for
// pps_generator. Expected pulse timing, seconds and counters come from a
// reference model of the once-per-second rules held in plain variables.
module tb_pps_generator;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        axi_reset;
   logic [63:0] stamp;
   logic        time_jump;
   logic        enable;
   logic [31:0] pps_offset;
   logic [31:0] pulse_width;
   logic        pps_tx;
   logic [31:0] pps_count;
   logic [31:0] pps_seconds;
   logic [31:0] missed_count;

   pps_generator #(.TIMESTAMP_WIDTH(64), .C_S_AXI_DATA_WIDTH(32)) dut (
      .axi_aclk      (clk),
      .axi_reset     (axi_reset),
      .stamp_counter (stamp),
      .time_jump     (time_jump),
      .enable        (enable),
      .pps_offset    (pps_offset),
      .pulse_width   (pulse_width),
      .pps_tx        (pps_tx),
      .pps_count     (pps_count),
      .pps_seconds   (pps_seconds),
      .missed_count  (missed_count)
   );

   int checks = 0;
   int errors = 0;

   // stamp handling: cur_sampled is the stamp the DUT saw at the latest edge
   logic [63:0] step = 64'd28;
   logic [63:0] cur_sampled  = '0;
   logic [63:0] prev_sampled = '0;

   // ---------------- reference model ----------------
   logic [31:0] exp_t      = '0;  // second of the next pulse
   logic [31:0] exp_count  = '0;
   logic [31:0] exp_missed = '0;
   logic [31:0] exp_q[$];         // expected pps_seconds per emitted pulse

   // Has time s reached the point (sec, off)? Modular so the 64-bit wrap works.
   function automatic bit reached(input logic [63:0] s, input logic [31:0] sec,
                                  input logic [31:0] off);
      logic [63:0] d;
      d = s - {sec, off};
      return !d[63];
   endfunction

   function automatic void model_arm(input logic [31:0] sec_now);
      exp_t = sec_now + 32'd1;
   endfunction

   // A pulse fired on the stamp in cur_sampled.
   function automatic void model_fire();
      logic [31:0] s;
      logic [31:0] ahead;
      s     = cur_sampled[63:32];
      ahead = s - exp_t;
      exp_q.push_back(exp_t);
      exp_count = exp_count + 32'd1;
      if (!ahead[31] && (ahead != 32'd0)) begin
         exp_missed = exp_missed + ahead;
         exp_t      = s + 32'd1;
      end else begin
         exp_t = exp_t + 32'd1;
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      prev_sampled = cur_sampled;
      cur_sampled  = stamp;
      @(posedge clk);
      #1;
      stamp = stamp + step;
   endtask

   task automatic wait_rise(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (pps_tx === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   // Called right after a rise was seen; returns the number of high cycles.
   task automatic count_high(input int budget, output int n);
      n = 1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (pps_tx !== 1'b1) break;
         n++;
      end
   endtask

   // Called right after the first low cycle; returns low cycles until next rise.
   task automatic count_low(input int budget, output int n);
      n = 1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (pps_tx === 1'b1) break;
         n++;
      end
   endtask

   task automatic count_pulses(input int cycles, output int highs);
      highs = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (pps_tx === 1'b1) highs++;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      axi_reset = 1'b1;
      repeat (3) tick();
      axi_reset = 1'b0;
      checks++; if (pps_tx !== 1'b0) begin errors++; $display("FAIL reset_tx got %0b want 0", pps_tx); end
      checks++; if (pps_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", pps_count); end
      checks++; if (pps_seconds !== 32'd0) begin errors++; $display("FAIL reset_seconds got %0d want 0", pps_seconds); end
      checks++; if (missed_count !== 32'd0) begin errors++; $display("FAIL reset_missed got %0d want 0", missed_count); end
   endtask

   task automatic test_first_pulse();
      bit seen; int n; logic [31:0] es;
      pps_offset  = 32'd0;
      pulse_width = 32'd4;
      stamp       = 64'h00000005_FFFFFF00;
      enable      = 1'b1;
      model_arm(stamp[63:32]);
      wait_rise(100, seen);
      checks++; if (!seen) begin errors++; $display("FAIL first_rise_seen got 0 want 1"); end
      checks++;
      if (!(reached(cur_sampled, exp_t, 32'd0) && !reached(prev_sampled, exp_t, 32'd0))) begin
         errors++; $display("FAIL first_rise_time stamp %h prev %h want first >= %h_00000000", cur_sampled, prev_sampled, exp_t);
      end
      model_fire();
      es = exp_q.pop_front();
      checks++; if (pps_seconds !== es) begin errors++; $display("FAIL first_seconds got %0d want %0d", pps_seconds, es); end
      checks++; if (pps_count !== exp_count) begin errors++; $display("FAIL first_count got %0d want %0d", pps_count, exp_count); end
      count_high(20, n);
      checks++; if (n != 4) begin errors++; $display("FAIL first_width got %0d want 4", n); end
   endtask

   task automatic test_offset_phase();
      bit seen; int n; int highs; logic [31:0] es;
      pps_offset  = 32'h80000000;
      pulse_width = 32'd3;
      for (int k = 0; k < 2; k++) begin
         // crossing the whole second must not fire
         stamp = {exp_t, 32'd0} - 64'd140;
         count_pulses(20, highs);
         checks++; if (highs != 0) begin errors++; $display("FAIL whole_sec_quiet got %0d high cycles want 0", highs); end
         stamp = {exp_t, 32'h80000000} - 64'd140;
         wait_rise(40, seen);
         checks++;
         if (!seen || !(reached(cur_sampled, exp_t, pps_offset) && !reached(prev_sampled, exp_t, pps_offset))) begin
            errors++; $display("FAIL half_sec_rise seen %0b stamp %h prev %h want first >= %h_80000000", seen, cur_sampled, prev_sampled, exp_t);
         end
         model_fire();
         es = exp_q.pop_front();
         checks++; if (pps_seconds !== es) begin errors++; $display("FAIL half_sec_seconds got %0d want %0d", pps_seconds, es); end
         count_high(20, n);
         checks++; if (n != 3) begin errors++; $display("FAIL half_sec_width got %0d want 3", n); end
      end
   endtask

   task automatic test_missed();
      bit seen; int n; logic [31:0] es;
      pps_offset  = 32'd0;
      pulse_width = 32'd2;
      stamp = {exp_t, 32'd0} - 64'd140;     // pulse at 9 leaves the target at 10
      wait_rise(40, seen);
      model_fire();
      void'(exp_q.pop_front());
      count_high(20, n);
      stamp = 64'h0000000D_00000010;
      wait_rise(5, seen);
      checks++; if (!seen) begin errors++; $display("FAIL missed_rise_seen got 0 want 1"); end
      model_fire();
      es = exp_q.pop_front();
      checks++; if (pps_seconds !== es) begin errors++; $display("FAIL missed_seconds got %0d want %0d", pps_seconds, es); end
      checks++; if (missed_count !== exp_missed) begin errors++; $display("FAIL missed_count got %0d want %0d", missed_count, exp_missed); end
      count_high(20, n);
      stamp = {exp_t, 32'd0} - 64'd168;
      wait_rise(40, seen);
      checks++;
      if (!seen || !(reached(cur_sampled, exp_t, 32'd0) && !reached(prev_sampled, exp_t, 32'd0))) begin
         errors++; $display("FAIL after_missed_rise seen %0b stamp %h want first >= %h_00000000", seen, cur_sampled, exp_t);
      end
      model_fire();
      es = exp_q.pop_front();
      checks++; if (pps_seconds !== es) begin errors++; $display("FAIL after_missed_seconds got %0d want %0d", pps_seconds, es); end
      count_high(20, n);
   endtask

   task automatic test_time_jump();
      bit seen; int n; logic [31:0] es;
      pulse_width = 32'd10;
      stamp = {exp_t, 32'd0} - 64'd140;
      wait_rise(40, seen);
      model_fire();
      void'(exp_q.pop_front());
      tick(); tick();
      time_jump = 1'b1;
      stamp     = 64'h00000002_00000000;
      tick();
      time_jump = 1'b0;
      model_arm(32'd2);
      checks++; if (pps_tx !== 1'b0) begin errors++; $display("FAIL jump_truncate got %0b want 0", pps_tx); end
      checks++; if (pps_count !== exp_count) begin errors++; $display("FAIL jump_count got %0d want %0d", pps_count, exp_count); end
      repeat (4) tick();
      stamp = {exp_t, 32'd0} - 64'd140;
      wait_rise(40, seen);
      checks++;
      if (!seen || !(reached(cur_sampled, exp_t, 32'd0) && !reached(prev_sampled, exp_t, 32'd0))) begin
         errors++; $display("FAIL jump_rise seen %0b stamp %h want first >= %h_00000000", seen, cur_sampled, exp_t);
      end
      model_fire();
      es = exp_q.pop_front();
      checks++; if (pps_seconds !== es) begin errors++; $display("FAIL jump_seconds got %0d want %0d", pps_seconds, es); end
      count_high(40, n);
   endtask

   task automatic test_width_edges();
      bit seen; int n; int lo; int w; logic [31:0] es;
      pulse_width = 32'd0;
      stamp = {exp_t, 32'd0} - 64'd140;
      wait_rise(40, seen);
      model_fire();
      void'(exp_q.pop_front());
      count_high(20, n);
      checks++; if (n != 1) begin errors++; $display("FAIL width0 got %0d want 1", n); end
      w = $urandom_range(20, 40);
      pulse_width = w;
      stamp = {exp_t, 32'd0} - 64'd140;
      wait_rise(40, seen);
      model_fire();
      void'(exp_q.pop_front());
      // new width ignored by the pulse in flight; time runs past the next target
      pulse_width = 32'd1;
      stamp = {exp_t, 32'h00000100};
      count_high(100, n);
      checks++; if (n != w) begin errors++; $display("FAIL long_width got %0d want %0d", n, w); end
      // low for the GAP cycle plus the WAIT cycle that samples the compare
      count_low(20, lo);
      checks++; if (lo != 2) begin errors++; $display("FAIL gap_low got %0d want 2", lo); end
      model_fire();
      es = exp_q.pop_front();
      checks++; if (pps_seconds !== es) begin errors++; $display("FAIL gap_seconds got %0d want %0d", pps_seconds, es); end
      count_high(20, n);
   endtask

   task automatic test_backwards();
      bit seen; int n; int highs; logic [31:0] es;
      pulse_width = 32'd2;
      stamp = {exp_t - 32'd4, 32'd0};
      model_arm(exp_t - 32'd4);
      count_pulses(10, highs);
      checks++; if (highs != 0) begin errors++; $display("FAIL back_quiet got %0d high cycles want 0", highs); end
      stamp = {exp_t, 32'd0} - 64'd140;
      wait_rise(40, seen);
      checks++;
      if (!seen || !(reached(cur_sampled, exp_t, 32'd0) && !reached(prev_sampled, exp_t, 32'd0))) begin
         errors++; $display("FAIL back_rise seen %0b stamp %h want first >= %h_00000000", seen, cur_sampled, exp_t);
      end
      model_fire();
      es = exp_q.pop_front();
      checks++; if (pps_seconds !== es) begin errors++; $display("FAIL back_seconds got %0d want %0d", pps_seconds, es); end
      count_high(20, n);
   endtask

   task automatic test_enable_wrap();
      bit seen; int n; logic [31:0] es;
      pulse_width = 32'd10;
      stamp = {exp_t, 32'd0} - 64'd140;
      wait_rise(40, seen);
      model_fire();
      void'(exp_q.pop_front());
      tick(); tick();
      enable = 1'b0;
      tick();
      checks++; if (pps_tx !== 1'b0) begin errors++; $display("FAIL disable_tx got %0b want 0", pps_tx); end
      checks++; if (pps_count !== exp_count) begin errors++; $display("FAIL disable_count got %0d want %0d", pps_count, exp_count); end
      repeat (3) tick();
      pps_offset = 32'd0;
      step   = 64'h00000000_01000000;
      stamp  = 64'hFFFFFFFF_F0000000;
      enable = 1'b1;
      model_arm(32'hFFFFFFFF);
      wait_rise(40, seen);
      checks++;
      if (!seen || !(reached(cur_sampled, exp_t, 32'd0) && !reached(prev_sampled, exp_t, 32'd0))) begin
         errors++; $display("FAIL wrap_rise seen %0b stamp %h prev %h want first >= %h_00000000", seen, cur_sampled, prev_sampled, exp_t);
      end
      model_fire();
      es = exp_q.pop_front();
      checks++; if (pps_seconds !== es) begin errors++; $display("FAIL wrap_seconds got %0d want %0d", pps_seconds, es); end
      step = 64'd28;
      count_high(20, n);
   endtask

   task automatic test_random();
      bit seen; int n; int w; int k; int extra; logic [31:0] off; logic [31:0] es;
      for (int r = 0; r < 8; r++) begin
         off   = $urandom;
         w     = $urandom_range(1, 6);
         k     = $urandom_range(5, 30);
         extra = $urandom_range(0, 2);
         pps_offset  = off;
         pulse_width = w;
         stamp = {exp_t + extra, off} - (64'd28 * k);
         wait_rise(80, seen);
         checks++;
         if (!seen || (extra == 0 && !(reached(cur_sampled, exp_t, off) && !reached(prev_sampled, exp_t, off)))) begin
            errors++; $display("FAIL rand_rise r%0d seen %0b stamp %h want first >= %h_%h", r, seen, cur_sampled, exp_t, off);
         end
         model_fire();
         es = exp_q.pop_front();
         checks++; if (pps_seconds !== es) begin errors++; $display("FAIL rand_seconds r%0d got %0d want %0d", r, pps_seconds, es); end
         checks++; if (missed_count !== exp_missed) begin errors++; $display("FAIL rand_missed r%0d got %0d want %0d", r, missed_count, exp_missed); end
         checks++; if (pps_count !== exp_count) begin errors++; $display("FAIL rand_count r%0d got %0d want %0d", r, pps_count, exp_count); end
         count_high(20, n);
         checks++; if (n != w) begin errors++; $display("FAIL rand_width r%0d got %0d want %0d", r, n, w); end
      end
   endtask

   task automatic test_reset_mid_pulse();
      bit seen;
      pulse_width = 32'd10;
      pps_offset  = 32'd0;
      stamp = {exp_t, 32'd0} - 64'd140;
      wait_rise(40, seen);
      tick();
      axi_reset = 1'b1;
      tick();
      axi_reset = 1'b0;
      checks++; if (pps_tx !== 1'b0) begin errors++; $display("FAIL rst_pulse_tx got %0b want 0", pps_tx); end
      checks++; if (pps_count !== 32'd0) begin errors++; $display("FAIL rst_pulse_count got %0d want 0", pps_count); end
      checks++; if (missed_count !== 32'd0) begin errors++; $display("FAIL rst_pulse_missed got %0d want 0", missed_count); end
      checks++; if (pps_seconds !== 32'd0) begin errors++; $display("FAIL rst_pulse_seconds got %0d want 0", pps_seconds); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      axi_reset   = 1'b1;
      stamp       = '0;
      time_jump   = 1'b0;
      enable      = 1'b0;
      pps_offset  = '0;
      pulse_width = '0;
      test_reset();
      test_first_pulse();
      test_offset_phase();
      test_missed();
      test_time_jump();
      test_width_edges();
      test_backwards();
      test_enable_wrap();
      test_random();
      test_reset_mid_pulse();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
